// File: rtl/serial_parallel.sv
// Serial-to-parallel reassembler: collects LSB-first valid bits into WIDTH-bit
// words and queues completed words in a DEPTH-entry FIFO behind a valid/ready port.
module serial_parallel #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       serial_i,
    input  logic                       valid_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           parallel_o,
    output logic                       parallel_vld_o,
    input  logic                       parallel_rdy_i,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic             overflow;

    logic             capture;
    logic             complete;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] word_next;

    // A full FIFO still accepts a completed word when the head leaves on the same edge.
    always_comb begin
        capture   = valid_i && !flush_i;
        complete  = capture && (bit_cnt == LAST_BIT);
        pop       = (level != '0) && parallel_rdy_i;
        full      = (level == FULL_LVL);
        push      = complete && (!full || pop);
        drop      = complete && full && !pop;
        word_next = {serial_i, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (flush_i) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (valid_i) begin
            shreg   <= word_next;
            bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word_next;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign parallel_o     = (level != '0) ? mem[rd_ptr] : '0;
    assign parallel_vld_o = (level != '0);
    assign bit_cnt_o      = bit_cnt;
    assign level_o        = level;
    assign overflow_o     = overflow;

endmodule

// File: tb/tb_serial_parallel.sv
// Scoreboard bench for serial_parallel: a queue-based reference model predicts
// accepted words, a negedge monitor checks each handshake against it.
module tb_serial_parallel;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic                       clk;
    logic                       reset;
    logic                       serial_i;
    logic                       valid_i;
    logic                       flush_i;
    logic [WIDTH-1:0]           parallel_o;
    logic                       parallel_vld_o;
    logic                       parallel_rdy_i;
    logic [$clog2(WIDTH)-1:0]   bit_cnt_o;
    logic [$clog2(DEPTH):0]     level_o;
    logic                       overflow_o;

    serial_parallel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_i       (serial_i),
        .valid_i        (valid_i),
        .flush_i        (flush_i),
        .parallel_o     (parallel_o),
        .parallel_vld_o (parallel_vld_o),
        .parallel_rdy_i (parallel_rdy_i),
        .bit_cnt_o      (bit_cnt_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: words the FIFO holds, plus the partial word in progress.
    int sb[$];
    int mdl_acc   = 0;
    int mdl_bits  = 0;
    int mdl_level = 0;
    int mdl_ovf   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit do_pop;
        if (reset) begin
            sb.delete();
            mdl_acc = 0; mdl_bits = 0; mdl_level = 0; mdl_ovf = 0;
        end else begin
            do_pop = (mdl_level > 0) && parallel_rdy_i;
            if (flush_i) begin
                mdl_acc = 0; mdl_bits = 0; mdl_ovf = 0;
            end else if (valid_i) begin
                mdl_acc  = mdl_acc + (int'(serial_i) << mdl_bits);
                mdl_bits = mdl_bits + 1;
                if (mdl_bits == WIDTH) begin
                    if (mdl_level < DEPTH || do_pop) begin
                        sb.push_back(mdl_acc);
                        mdl_level++;
                    end else begin
                        mdl_ovf = 1;
                    end
                    mdl_acc = 0; mdl_bits = 0;
                end
            end
            if (do_pop) mdl_level--;
        end
    endtask

    task automatic checkOutput();
        check("bit_cnt", 32'(bit_cnt_o), 32'(mdl_bits));
        check("level", 32'(level_o), 32'(mdl_level));
        check("overflow", 32'(overflow_o), 32'(mdl_ovf));
        check("valid", 32'(parallel_vld_o), 32'(mdl_level > 0));
        if (sb.size() == 0) check("empty_word", 32'(parallel_o), 32'd0);
        else                check("head_word", 32'(parallel_o), 32'(sb[0]));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then check.
    task automatic applyStimulus(input logic v, input logic s, input logic f,
                                 input logic r, input logic rst);
        valid_i = v; serial_i = s; flush_i = f; parallel_rdy_i = r; reset = rst;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input int max_gap,
                            input logic rdy, input logic last_rdy);
        for (int i = 0; i < WIDTH; i++) begin
            for (int g = $urandom_range(max_gap, 0); g > 0; g--)
                applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
            applyStimulus(1'b1, w[i], 1'b0, (i == WIDTH - 1) ? last_rdy : rdy, 1'b0);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Handshake monitor: a pop happens on the next rising edge, so compare now.
    always @(negedge clk) begin
        if (!reset && parallel_vld_o && parallel_rdy_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL pop_unexpected: got word %0d, expected no valid word at %0t",
                         parallel_o, $time);
            end else begin
                check("pop_word", 32'(parallel_o), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        valid_i = 0; serial_i = 0; flush_i = 0; parallel_rdy_i = 0; reset = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_word", 32'(parallel_o), 32'd0);

        // Single word 1,0,1,1 -> 4'hD, popped the edge after it appears.
        sendWord(4'hD, 0, 1'b1, 1'b1);
        check("single_word", 32'(parallel_o), 32'hD);
        idle(2, 1'b1);
        check("single_drained", 32'(level_o), 32'd0);

        // Same word with random gaps between bits.
        sendWord(4'hD, 3, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: third word is dropped, first two drain in order.
        sendWord(4'h3, 1, 1'b0, 1'b0);
        sendWord(4'h5, 1, 1'b0, 1'b0);
        sendWord(4'h9, 1, 1'b0, 1'b0);
        check("bp_level", 32'(level_o), 32'd2);
        check("bp_overflow", 32'(overflow_o), 32'd1);
        idle(4, 1'b1);

        // Full FIFO with a pop on the completing edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sendWord(4'hA, 0, 1'b0, 1'b0);
        sendWord(4'hB, 0, 1'b0, 1'b0);
        sendWord(4'hC, 0, 1'b0, 1'b1);
        check("full_pop_level", 32'(level_o), 32'd2);
        check("full_pop_ovf", 32'(overflow_o), 32'd0);
        idle(4, 1'b1);

        // Flush mid-word after an overflow.
        sendWord(4'h1, 0, 1'b0, 1'b0);
        sendWord(4'h2, 0, 1'b0, 1'b0);
        sendWord(4'h3, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("flush_cnt", 32'(bit_cnt_o), 32'd0);
        check("flush_ovf", 32'(overflow_o), 32'd0);
        check("flush_level", 32'(level_o), 32'd2);
        idle(3, 1'b1);
        sendWord(4'h6, 0, 1'b1, 1'b1);
        check("post_flush_word", 32'(parallel_o), 32'h6);
        idle(2, 1'b1);

        // Reset with one queued word and three bits in flight.
        sendWord(4'h7, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_cnt", 32'(bit_cnt_o), 32'd0);
        check("rst_mid_vld", 32'(parallel_vld_o), 32'd0);
        sendWord(4'hE, 0, 1'b1, 1'b1);
        check("post_reset_word", 32'(parallel_o), 32'hE);
        idle(2, 1'b1);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          1'($urandom_range(15, 0) == 0), 1'($urandom_range(2, 0) != 0),
                          1'($urandom_range(63, 0) == 0));
        end
        idle(DEPTH + 2, 1'b1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
- Downstream neighbour of the 4-bit parallel-to-serial shifter. Consumes its LSB-first serial bit stream and per-bit valid.
- Reassembles each run of WIDTH valid bits into a parallel word.
- Buffers completed words in a small DEPTH-entry FIFO and presents them on a valid/ready output port.
- Reports an in-progress bit count, FIFO level and a sticky overflow flag.

Parameters:
- WIDTH, 4, bits per assembled word; legal range 2 or more.
- DEPTH, 2, output FIFO entries; must be a power of 2, 2 or more.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- serial_i  in  1  serial data bit, LSB first.
- valid_i  in  1  serial_i carries a valid bit this cycle.
- flush_i  in  1  discard the partial word and clear overflow_o; FIFO contents kept.
- parallel_o  out  WIDTH  head-of-FIFO word.
- parallel_vld_o  out  1  FIFO not empty.
- parallel_rdy_i  in  1  consumer accepts the head word when parallel_vld_o is also 1.
- bit_cnt_o  out  $clog2(WIDTH)  number of bits collected toward the current word.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0 to DEPTH.
- overflow_o  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset is synchronous: sampled on the rising edge of clk with reset=1.
  - Values after reset: bit_cnt_o=0, level_o=0, parallel_vld_o=0, overflow_o=0, parallel_o=0.
  - Assembly shift register and all FIFO storage are cleared to 0.
  - Reset applied mid-word or mid-drain discards everything.
- Bit capture: each edge with valid_i=1 and flush_i=0 captures serial_i.
  - The shift register shifts right; the new bit enters the MSB.
  - The first bit of a word therefore ends up in parallel_o[0].
  - bit_cnt increments by 1.
  - Cycles with valid_i=0 hold all assembly state; gaps between bits are allowed.
- Word completion: a captured bit with bit_cnt==WIDTH-1 completes a word.
  - The completed word is {serial_i, shreg[WIDTH-1:1]}.
  - It is pushed into the FIFO on that same edge, and bit_cnt wraps to 0.
  - parallel_vld_o rises in the cycle after the last bit, i.e. 1-cycle latency from the last valid bit to the word being visible.
- Pop: occurs on an edge where parallel_vld_o=1 and parallel_rdy_i=1.
  - parallel_o changes only on a pop, or on a push into an empty FIFO.
  - parallel_o is 0 whenever the FIFO is empty.
  - parallel_rdy_i while the FIFO is empty has no effect.
- FIFO structure: circular buffer with read and write pointers that wrap modulo DEPTH.
  - level_o is updated as follows: +1 on push only, -1 on pop only, unchanged on a simultaneous push and pop.
- Full FIFO (level_o==DEPTH) at a completion edge:
  - If a pop occurs on the same edge, the push is accepted and level_o stays at DEPTH.
  - Otherwise the completed word is dropped, overflow_o is set to 1, FIFO contents are unchanged, and bit_cnt still wraps to 0.
- flush_i=1 on an edge:
  - Clears bit_cnt and the shift register, and clears overflow_o.
  - The valid_i bit on that edge is discarded; flush wins over capture.
  - A pop on the same edge still proceeds; FIFO contents are otherwise untouched.
- overflow_o stays at 1 until reset or flush_i.
- No combinational path from any input to any output: all outputs are registered or decoded from registers.

Test Plan (WIDTH=4, DEPTH=2):
- Single word: reset, then bits 1,0,1,1 on 4 consecutive cycles with valid_i=1 and rdy=1 -> parallel_vld_o=1 with parallel_o=4'hD one cycle after the 4th bit; pop next edge; level_o returns to 0.
- Gapped bits: the same 4 bits with valid_i=0 gaps of 0-3 random cycles -> bit_cnt_o steps 1,2,3 and holds through gaps; parallel_o=4'hD.
- Back-pressure and overflow: rdy=0; words 4'h3, 4'h5, 4'h9 -> level_o=2 and overflow_o=1 after the 3rd word; then rdy=1 drains 4'h3 then 4'h5 only.
- Full with simultaneous pop: FIFO holds 4'hA, 4'hB; rdy=1 on the edge that completes 4'hC -> no overflow, level_o stays 2, subsequent pops give 4'hB then 4'hC.
- Flush mid-word: 2 bits captured, then flush_i=1 with valid_i=1 -> bit_cnt_o=0, overflow_o cleared, FIFO unchanged; the next 4 bits form a clean word.
- Reset mid-operation: FIFO holds 1 word and bit_cnt_o=3; assert reset for 1 cycle -> all outputs 0 and the following word assembles correctly from bit 0.
